// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MIPS multiply/divide unit owning the HI/LO pair
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining multiplier bits are zero.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/i_funct/i_rs/i_rt issue a HI/LO-class op;
// i_flush squashes an in-flight op; o_stall holds EX while busy; o_busy/o_done/o_div_zero report status;
// o_mf_data is the MFHI/MFLO read; o_hi/o_lo expose the HI/LO registers.
module muldiv_sequencer #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6,
    parameter int NB_COUNT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_rs,
    input  logic [NB_DATA-1:0]  i_rt,
    input  logic                i_flush,
    output logic                o_stall,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_div_zero,
    output logic [NB_DATA-1:0]  o_mf_data,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo
);
    localparam logic [NB_FUNCT-1:0] F_MULT  = 6'b011000;
    localparam logic [NB_FUNCT-1:0] F_MULTU = 6'b011001;
    localparam logic [NB_FUNCT-1:0] F_DIV   = 6'b011010;
    localparam logic [NB_FUNCT-1:0] F_DIVU  = 6'b011011;
    localparam logic [NB_FUNCT-1:0] F_MTHI  = 6'b010001;
    localparam logic [NB_FUNCT-1:0] F_MFLO  = 6'b010010;
    localparam logic [NB_FUNCT-1:0] F_MTLO  = 6'b010011;
    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;
    state_t                 state;
    logic [NB_COUNT-1:0]    cnt;
    logic [2*NB_DATA-1:0]   acc, mc, mul_acc, prod;
    logic [NB_DATA-1:0]     mp, hi, lo, abs_a, abs_b, quot, rem;
    logic [NB_DATA:0]       div_t;
    logic                   is_div, neg_q, neg_r, dz, idle_ok, start, sa, sb, div_ok, last;
    // For divide, acc[NB_DATA-1:0] is the partial remainder, mp shifts dividend bits out and quotient bits in,
    // and mc[NB_DATA-1:0] holds the divisor; for multiply acc/mc/mp are product/multiplicand/multiplier.
    assign idle_ok = (state == IDLE) & i_valid & ~i_flush;
    assign start   = idle_ok & (i_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign sa      = ~i_funct[0] & i_rs[NB_DATA-1];
    assign sb      = ~i_funct[0] & i_rt[NB_DATA-1];
    assign abs_a   = sa ? -i_rs : i_rs;
    assign abs_b   = sb ? -i_rt : i_rt;
    assign mul_acc = acc + (mp[0] ? mc : '0);
    assign div_t   = {acc[NB_DATA-1:0], mp[NB_DATA-1]} - {1'b0, mc[NB_DATA-1:0]};
    assign div_ok  = ~div_t[NB_DATA];
`ifdef MULDIV_EARLY_OUT_EN
    assign last    = (cnt == NB_COUNT'(NB_DATA-1)) | (~is_div & (mp[NB_DATA-1:1] == '0));
`else
    assign last    = cnt == NB_COUNT'(NB_DATA-1);
`endif
    assign prod    = neg_q ? -acc : acc;
    // Division by zero leaves the full dividend magnitude as remainder, so only LO needs forcing.
    assign quot    = dz ? '1 : neg_q ? -mp : mp;
    assign rem     = neg_r ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
    assign o_stall   = i_valid & (state != IDLE);
    assign o_busy    = state != IDLE;
    assign o_mf_data = (i_funct == F_MFLO) ? lo : hi;
    assign o_hi      = hi;
    assign o_lo      = lo;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            mc         <= '0;
            mp         <= '0;
            hi         <= '0;
            lo         <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz         <= 1'b0;
            o_done     <= 1'b0;
            o_div_zero <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_div_zero <= 1'b0;
            if (state != IDLE && i_flush) begin
                state <= IDLE;
            end else if (start) begin
                state  <= RUN;
                cnt    <= '0;
                acc    <= '0;
                is_div <= i_funct[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                dz     <= i_funct[1] & (i_rt == '0);
                mc     <= {{NB_DATA{1'b0}}, i_funct[1] ? abs_b : abs_a};
                mp     <= i_funct[1] ? abs_a : abs_b;
            end else if (idle_ok) begin
                if (i_funct == F_MTHI) hi <= i_rs;
                if (i_funct == F_MTLO) lo <= i_rs;
            end else if (state == RUN) begin
                cnt   <= cnt + 1'b1;
                state <= last ? SIGN : RUN;
                if (is_div) begin
                    acc[NB_DATA-1:0] <= div_ok ? div_t[NB_DATA-1:0] : {acc[NB_DATA-2:0], mp[NB_DATA-1]};
                    mp               <= {mp[NB_DATA-2:0], div_ok};
                end else begin
                    acc <= mul_acc;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                end
            end else if (state == SIGN) begin
                state      <= IDLE;
                hi         <= is_div ? rem : prod[2*NB_DATA-1:NB_DATA];
                lo         <= is_div ? quot : prod[NB_DATA-1:0];
                o_done     <= 1'b1;
                o_div_zero <= dz;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] rs = '0, rt = '0;
    logic        stall, busy, done, div_zero;
    logic [31:0] mf_data, hi, lo;
    int vectors = 0, fails = 0;
    always #5 clk = ~clk;
    muldiv_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_funct(funct), .i_rs(rs), .i_rt(rt),
        .i_flush(flush), .o_stall(stall), .o_busy(busy), .o_done(done), .o_div_zero(div_zero),
        .o_mf_data(mf_data), .o_hi(hi), .o_lo(lo)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Reference results from plain 64-bit arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = 1'b0;
        case (f)
            F_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            F_MULTU: begin p = 64'(a) * 64'(b); eh = p[63:32]; el = p[31:0]; end
            F_DIV: begin
                if (b == 0) begin eh = a; el = '1; ez = 1'b1; end
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
            end
            default: begin
                if (b == 0) begin eh = a; el = '1; ez = 1'b1; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask
    // Negedges from acceptance until o_done is seen: RUN cycles plus SIGN plus acceptance.
    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
        int r;
        logic [31:0] ab;
        r = 32;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[1]) begin
            ab = (!f[0] && b[31]) ? -b : b;
            r = 1;
            for (int i = 0; i < 32; i++) if (ab[i]) r = i + 1;
        end
`endif
        return r + 2;
    endfunction
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic ez;
        int k, busy_n, ek;
        model(f, a, b, eh, el, ez);
        ek = exp_lat(f, b);
        @(negedge clk);
        valid = 1'b1; funct = f; rs = a; rt = b;
        #1 check("accept_stall", stall, 0);
        @(negedge clk);
        valid = 1'b0;
        k = 1;
        busy_n = 0;
        while (!done && k < 60) begin
            busy_n += int'(busy);
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        check("latency", k, ek);
        check("busy_cycles", busy_n, ek - 1);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("div_zero", div_zero, ez);
        valid = 1'b1; funct = F_MFLO;
        #1 check("mflo_stall", stall, 0);
        check("mflo_data", mf_data, el);
        funct = F_MFHI;
        #1 check("mfhi_data", mf_data, eh);
        valid = 1'b0;
    endtask
    initial begin
        logic [31:0] eh, el, old_hi, old_lo;
        logic ez;
        logic [5:0] fs [4];
        int k, done_n;
        fs = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        valid = 1'b1; funct = F_MFHI;
        #1 check("rst_mfhi", mf_data, 0);
        funct = F_MFLO;
        #1 check("rst_mflo", mf_data, 0);
        @(negedge clk);
        funct = F_MTHI; rs = 32'h1234;
        #1 check("mthi_stall", stall, 0);
        @(negedge clk);
        funct = F_MFHI;
        #1 check("mfhi_after_mthi", mf_data, 32'h1234);
        funct = F_MTLO; rs = 32'hCAFE_0001;
        @(negedge clk);
        funct = F_MFLO;
        #1 check("mflo_after_mtlo", mf_data, 32'hCAFE_0001);
        valid = 1'b0;
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op(F_DIVU, 32'd100, 32'd7);
        run_op(F_DIV, -32'sd100, 32'd7);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(F_DIVU, 32'd5, 32'd0);
        run_op(F_DIV, -32'sd7, 32'd0);
        run_op(F_MULTU, 32'd3, 32'd5);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000);
        // MFLO waiting behind a MULT stalls until the o_done cycle, then sees the new LO.
        model(F_MULT, 32'd1000, -32'sd3, eh, el, ez);
        @(negedge clk);
        valid = 1'b1; funct = F_MULT; rs = 32'd1000; rt = -32'sd3;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b1; funct = F_MFLO;
        k = 3;
        while (!done && k < 60) begin
            #1 check("mflo_wait_stall", stall, 1);
            @(negedge clk);
            k++;
        end
        #1 check("mflo_release_stall", stall, 0);
        check("mflo_release_data", mf_data, el);
        valid = 1'b0;
        // Flush at RUN cycle 10 aborts with HI/LO untouched and no o_done.
        old_hi = hi; old_lo = lo;
        @(negedge clk);
        valid = 1'b1; funct = F_DIVU; rs = 32'd999; rt = 32'd4;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        done_n = 0;
        repeat (40) begin @(negedge clk); done_n += int'(done); end
        check("flush_no_done", done_n, 0);
        check("flush_hi", hi, old_hi);
        check("flush_lo", lo, old_lo);
        // Flush in IDLE blocks acceptance; unknown funct is ignored.
        valid = 1'b1; funct = F_MULT; rs = 32'd2; rt = 32'd2; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; valid = 1'b0;
        check("idle_flush_busy", busy, 0);
        valid = 1'b1; funct = 6'b000000;
        @(negedge clk);
        valid = 1'b0;
        check("unknown_busy", busy, 0);
        check("unknown_hi", hi, old_hi);
        check("unknown_lo", lo, old_lo);
        for (int i = 0; i < 24; i++)
            run_op(fs[$urandom_range(0, 3)], $urandom(),
                   ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom() : $urandom_range(1, 300)));
        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        valid = 1'b1; funct = F_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F_DIV, 32'd77, -32'sd5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
